stream_pkt_sequencer: RTL and testbench

Packet sequencer between a raw Avalon-ST beat source (test counter or RF215 I/Q capture) and the DMA-facing Avalon-ST sink. On a start command it forwards a configured number of fixed-length packets and generates correct startofpacket/endofpacket framing. Beats outside a run are discarded. Software drives it through CSR-level pulses and reads progress from its status outputs.

---
 rtl/stream_pkg.sv | 15 +
 rtl/st_pipe_reg.sv | 43 ++++
 rtl/stream_pkt_sequencer.sv | 116 +++++++++++
 tb/tb_stream_pkt_sequencer.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/stream_pkg.sv
// Shared definitions for the stream sequencer and the stream generator.
package stream_pkg;

  localparam int DATA_W_DEF = 64;
  localparam int LEN_W_DEF  = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARM   = 3'd1,
    ST_RUN   = 3'd2,
    ST_FLUSH = 3'd3,
    ST_DRAIN = 3'd4
  } seq_state_t;

endpackage

// File: rtl/st_pipe_reg.sv
// Single-stage Avalon-ST register: data plus sop/eop framing, full-throughput valid/ready.
module st_pipe_reg
  import stream_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_sop,
  input  logic              in_eop,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_sop,
  output logic              out_eop,
  output logic              out_valid,
  input  logic              out_ready
);

  logic load;

  assign in_ready = !out_valid || out_ready;
  assign load     = in_valid && in_ready;

  // Stage boundary: upstream beat -> registered output
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= in_data;
      out_sop   <= in_sop;
      out_eop   <= in_eop;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/stream_pkt_sequencer.sv
// Packet sequencer: frames a raw beat stream into a configured number of fixed-length packets.
module stream_pkt_sequencer
  import stream_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_start,
  input  logic              cfg_stop,
  input  logic [LEN_W-1:0]  cfg_pkt_len,
  input  logic [LEN_W-1:0]  cfg_num_pkts,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sop,
  output logic              out_eop,
  output logic              busy,
  output logic              done,
  output logic [LEN_W-1:0]  pkt_cnt
);

  seq_state_t       state, state_nxt;
  logic [LEN_W-1:0] len_q, num_q, beat_idx, pkt_inc;
  logic             fwd, pipe_ready, load, last_beat, last_pkt, done_nxt;

  function automatic logic [LEN_W-1:0] eff_len(input logic [LEN_W-1:0] len);
    return (len == '0) ? LEN_W'(1) : len;
  endfunction

  assign fwd       = (state == ST_RUN) || (state == ST_FLUSH);
  assign in_ready  = fwd ? pipe_ready : (state == ST_IDLE);
  assign load      = fwd && in_valid && pipe_ready;
  assign last_beat = (beat_idx == len_q - LEN_W'(1));
  assign pkt_inc   = pkt_cnt + LEN_W'(1);
  assign last_pkt  = (num_q != '0) && (pkt_inc == num_q);

  // A stop landing on an eop beat ends the run there rather than flushing a whole extra packet.
  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cfg_start) state_nxt = ST_ARM;
      end
      ST_ARM: begin
        state_nxt = cfg_stop ? ST_IDLE : ST_RUN;
        done_nxt  = cfg_stop;
      end
      ST_RUN: begin
        if (load && last_beat && (last_pkt || cfg_stop)) begin
          state_nxt = ST_DRAIN;
        end else if (cfg_stop) begin
          state_nxt = ((beat_idx == '0) && !load) ? ST_DRAIN : ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (load && last_beat) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!out_valid || out_ready) begin
          state_nxt = ST_IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      pkt_cnt  <= '0;
      beat_idx <= '0;
      len_q    <= LEN_W'(1);
      num_q    <= '0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != ST_IDLE);
      done  <= done_nxt;
      if ((state == ST_IDLE) && cfg_start) begin
        len_q    <= eff_len(cfg_pkt_len);
        num_q    <= cfg_num_pkts;
        pkt_cnt  <= '0;
        beat_idx <= '0;
      end else if (load) begin
        beat_idx <= last_beat ? '0 : beat_idx + LEN_W'(1);
        if (last_beat) pkt_cnt <= pkt_inc;
      end
    end
  end

  st_pipe_reg #(
    .DATA_W(DATA_W)
  ) u_pipe (
    .clk      (clk),
    .reset    (reset),
    .in_data  (in_data),
    .in_sop   (beat_idx == '0),
    .in_eop   (last_beat),
    .in_valid (in_valid && fwd),
    .in_ready (pipe_ready),
    .out_data (out_data),
    .out_sop  (out_sop),
    .out_eop  (out_eop),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

endmodule

// File: tb/tb_stream_pkt_sequencer.sv
// Randomized bench for stream_pkt_sequencer against a queue-based packet-framing model.
module tb_stream_pkt_sequencer;

  localparam int DATA_W = 64;
  localparam int LEN_W  = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              cfg_start, cfg_stop;
  logic [LEN_W-1:0]  cfg_pkt_len, cfg_num_pkts;
  logic [DATA_W-1:0] in_data;
  logic              in_valid, in_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_valid, out_ready, out_sop, out_eop;
  logic              busy, done;
  logic [LEN_W-1:0]  pkt_cnt;

  always #5 clk = ~clk;

  stream_pkt_sequencer #(.DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .reset(reset), .cfg_start(cfg_start), .cfg_stop(cfg_stop),
    .cfg_pkt_len(cfg_pkt_len), .cfg_num_pkts(cfg_num_pkts),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_sop(out_sop), .out_eop(out_eop), .busy(busy), .done(done), .pkt_cnt(pkt_cnt)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model state: accepted beats awaiting output, and packet framing expectations.
  logic [63:0] exp_q[$];
  int m_len = 1, m_num = 0, exp_pkts = -1;
  int acc_cnt = 0, out_beats = 0, pkts_out = 0, done_cnt = 0;
  int cyc = 0, start_cyc = 0, first_out_cyc = -1, last_out_cyc = 0;
  int t, k;
  bit live = 0, stop_seen = 0, pend_done = 0, hold_prev = 0;
  logic [63:0] hold_data;
  logic hold_sop, hold_eop;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic model_begin(input int len, input int num);
    m_len = (len == 0) ? 1 : len;
    m_num = num;
    exp_pkts = (num == 0) ? -1 : num;
    acc_cnt = 0; out_beats = 0; pkts_out = 0;
    stop_seen = 0; pend_done = 0; first_out_cyc = -1;
    exp_q.delete();
  endtask

  always @(negedge clk) begin
    if (pend_done) begin
      check("done_after_last_eop", done, 1);
      pend_done = 0;
    end
    if (done) begin
      done_cnt++;
      live = 0;
    end
    if (hold_prev) begin
      check("hold_data", out_data, hold_data);
      check("hold_sop", out_sop, hold_sop);
      check("hold_eop", out_eop, hold_eop);
    end
    hold_prev = out_valid && !out_ready;
    hold_data = out_data; hold_sop = out_sop; hold_eop = out_eop;
    if (!live) check("no_valid_outside_run", out_valid, 0);
    if (cfg_stop && live && !stop_seen) begin
      stop_seen = 1;
      t = (acc_cnt + ((in_valid && in_ready) ? 1 : 0) + m_len - 1) / m_len;
      if (m_num != 0 && t > m_num) t = m_num;
      exp_pkts = t;
    end
    if (live && in_valid && in_ready) begin
      exp_q.push_back(in_data);
      acc_cnt++;
    end
    if (out_valid && out_ready) begin
      if (first_out_cyc < 0) first_out_cyc = cyc;
      last_out_cyc = cyc;
      k = out_beats % m_len;
      if (exp_q.size() == 0) check("beat_without_input", 1, 0);
      else check("data_order", out_data, exp_q.pop_front());
      check("sop", out_sop, (k == 0));
      check("eop", out_eop, (k == m_len - 1));
      if (exp_pkts >= 0) check("beat_in_budget", (out_beats < exp_pkts * m_len), 1);
      out_beats++;
      if (k == m_len - 1) begin
        pkts_out++;
        if (pkts_out == exp_pkts) pend_done = 1;
      end
    end
    if (cfg_start && !live && !reset) begin
      live = 1;
      start_cyc = cyc;
    end
  end

  task automatic do_run(input int len, input int num, input bit rnd_rdy, input bit rnd_vld,
                        input int stop_at, input int rst_at, input bit start_stop, input string name);
    int d0;
    bit stopped;
    model_begin(len, num);
    d0 = done_cnt;
    stopped = 0;
    @(posedge clk); #1;
    cfg_pkt_len = LEN_W'(len); cfg_num_pkts = LEN_W'(num);
    cfg_start = 1; cfg_stop = start_stop;
    in_valid = 1; in_data = {$urandom, $urandom}; out_ready = 1;
    @(posedge clk); #1;
    cfg_start = 0; cfg_stop = 0;
    cfg_pkt_len = LEN_W'($urandom); cfg_num_pkts = LEN_W'($urandom);
    for (int b = 0; b < 2000 && done_cnt == d0; b++) begin
      in_valid  = rnd_vld ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data   = {$urandom, $urandom};
      out_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      cfg_stop  = 0;
      if (stop_at >= 0 && !stopped && out_beats >= stop_at) begin
        cfg_stop = 1;
        stopped = 1;
      end
      if (rst_at >= 0 && out_beats >= rst_at) begin
        #1 reset = 1;
        #1;
        check({name, "_valid_drop"}, out_valid, 0);
        check({name, "_busy_drop"}, busy, 0);
        check({name, "_in_ready_idle"}, in_ready, 1);
        check({name, "_pkt_cnt_clear"}, pkt_cnt, 0);
        live = 0; hold_prev = 0; pend_done = 0;
        exp_q.delete();
        @(posedge clk); #1;
        reset = 0;
        return;
      end
      @(posedge clk); #1;
    end
    check({name, "_done_pulses"}, done_cnt - d0, 1);
    cfg_stop = 0; out_ready = 1;
    check({name, "_done_width"}, done, 0);
    check({name, "_busy_after"}, busy, 0);
    check({name, "_pkt_cnt"}, pkt_cnt, LEN_W'(exp_pkts));
    check({name, "_beats"}, out_beats, exp_pkts * m_len);
    check({name, "_queue_empty"}, exp_q.size(), 0);
    repeat (2) begin
      in_valid = 1'($urandom_range(0, 1)); in_data = {$urandom, $urandom};
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int d0;
    reset = 1; cfg_start = 0; cfg_stop = 0; cfg_pkt_len = '0; cfg_num_pkts = '0;
    in_data = '0; in_valid = 0; out_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_sop", out_sop, 0);
    check("rst_out_eop", out_eop, 0);
    check("rst_out_data", out_data, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_pkt_cnt", pkt_cnt, 0);
    check("rst_in_ready", in_ready, 1);
    reset = 0;

    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      in_valid = ~in_valid; in_data = {$urandom, $urandom};
      check("idle_in_ready", in_ready, 1);
      check("idle_out_valid", out_valid, 0);
    end
    in_valid = 0;

    d0 = done_cnt;
    @(posedge clk); #1 cfg_stop = 1;
    @(posedge clk); #1 cfg_stop = 0;
    repeat (4) @(posedge clk);
    #1 check("idle_stop_no_done", done_cnt - d0, 0);

    do_run(4, 3, 0, 0, -1, -1, 0, "basic");
    check("basic_latency", first_out_cyc - start_cyc, 3);
    check("basic_throughput", last_out_cyc - first_out_cyc, 11);

    do_run(5, 2, 1, 1, -1, -1, 0, "backpressure");
    do_run(8, 0, 0, 0, 11, -1, 0, "cont_stop");
    check("cont_stop_two_pkts", pkt_cnt, 2);
    do_run(0, 2, 0, 0, -1, -1, 0, "len0");
    check("len0_beats", out_beats, 2);

    model_begin(4, 2);
    d0 = done_cnt;
    @(posedge clk); #1;
    cfg_pkt_len = 4; cfg_num_pkts = 2; cfg_start = 1; in_valid = 1;
    @(posedge clk); #1;
    cfg_start = 0; cfg_stop = 1;
    @(posedge clk); #1;
    cfg_stop = 0;
    check("arm_stop_done", done, 1);
    check("arm_stop_busy", busy, 0);
    @(posedge clk); #1;
    check("arm_stop_done_pulse", done, 0);
    repeat (3) @(posedge clk);
    #1;
    check("arm_stop_done_count", done_cnt - d0, 1);
    check("arm_stop_no_beats", out_beats, 0);
    check("arm_stop_pkt_cnt", pkt_cnt, 0);

    do_run(6, 0, 0, 0, -1, 2, 0, "midrst");
    do_run(6, 1, 1, 0, -1, -1, 0, "after_rst");
    do_run(3, 2, 0, 0, -1, -1, 1, "start_stop");
    do_run(7, 3, 1, 1, -1, -1, 0, "random");
    do_run(3, 0, 1, 1, 7, -1, 0, "rand_stop");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
